// File: rtl/cfg_seq_pkg.sv
// Shared types and constants for the I2C sensor configuration sequencer.
// LUT entries are {reg addr[15:0], data[7:0]}.
package cfg_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PWRUP,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_SETTLE,
    S_DONE,
    S_FAIL
  } state_t;

  localparam int ADDR_MSB = 23;
  localparam int ADDR_LSB = 8;
  localparam int DATA_MSB = 7;

  localparam logic [15:0] SWRST_ADDR_DEF = 16'h0103;

  // Width holding 0..n-1, never below one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2c_cfg_sequencer_if.sv
// Register-write request channel between the sequencer and the I2C engine.
// done is a one-cycle pulse; nack is only meaningful with done.
interface i2c_cfg_sequencer_if;

  logic        req;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        done;
  logic        nack;

  modport master (
    output req, addr, wdata,
    input  done, nack
  );

  modport slave (
    input  req, addr, wdata,
    output done, nack
  );

endinterface

// File: rtl/cfg_delay_cnt.sv
// Loadable saturating down-counter; tc is high while the count is zero.
// Loading N-1 gives a tc on the N-th cycle after the load edge.
module cfg_delay_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - W'(1);
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/i2c_cfg_sequencer.sv
// Walks the sensor config LUT and issues each entry as an I2C register
// write, with power-up wait, soft-reset settle, timeout and retries.
module i2c_cfg_sequencer
  import cfg_seq_pkg::*;
#(
  parameter int          IDX_W          = 9,
  parameter int          PWRUP_CYCLES   = 20000,
  parameter logic [15:0] SWRST_ADDR     = SWRST_ADDR_DEF,
  parameter int          SWRST_CYCLES   = 10000,
  parameter int          TIMEOUT_CYCLES = 65535,
  parameter int          MAX_RETRY      = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [IDX_W-1:0]     lut_index,
  input  logic [23:0]          lut_data,
  input  logic [IDX_W-1:0]     lut_size,
  i2c_cfg_sequencer_if.master  i2c,
  output logic                 busy,
  output logic                 cfg_done,
  output logic                 cfg_fail,
  output logic [IDX_W-1:0]     fail_index
);

  localparam int PW = cnt_w(PWRUP_CYCLES);
  localparam int SW = cnt_w(SWRST_CYCLES);
  localparam int TW = cnt_w(TIMEOUT_CYCLES);
  localparam int RW = cnt_w(MAX_RETRY + 1);
  localparam logic [RW-1:0]    RMAX = RW'(MAX_RETRY);
  localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);

  state_t            state, state_n;
  logic [IDX_W-1:0]  idx_n, fidx_n;
  logic [15:0]       addr_n;
  logic [7:0]        wdata_n;
  logic              req_n, busy_n, done_n, fail_n;
  logic [RW-1:0]     retry, retry_n;
  logic              ld_pwr, ld_set, ld_to, adv;
  logic              pwr_tc, set_tc, to_tc;

  cfg_delay_cnt #(.W(PW)) u_pwr (
    .clk, .rst, .load(ld_pwr),
    .load_val(PW'(PWRUP_CYCLES - 1)), .tc(pwr_tc)
  );

  cfg_delay_cnt #(.W(SW)) u_set (
    .clk, .rst, .load(ld_set),
    .load_val(SW'(SWRST_CYCLES - 1)), .tc(set_tc)
  );

  cfg_delay_cnt #(.W(TW)) u_to (
    .clk, .rst, .load(ld_to),
    .load_val(TW'(TIMEOUT_CYCLES - 1)), .tc(to_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      lut_index  <= '0;
      i2c.req    <= 1'b0;
      i2c.addr   <= '0;
      i2c.wdata  <= '0;
      busy       <= 1'b0;
      cfg_done   <= 1'b0;
      cfg_fail   <= 1'b0;
      fail_index <= '0;
      retry      <= '0;
    end else begin
      state      <= state_n;
      lut_index  <= idx_n;
      i2c.req    <= req_n;
      i2c.addr   <= addr_n;
      i2c.wdata  <= wdata_n;
      busy       <= busy_n;
      cfg_done   <= done_n;
      cfg_fail   <= fail_n;
      fail_index <= fidx_n;
      retry      <= retry_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = lut_index;
    req_n   = i2c.req;
    addr_n  = i2c.addr;
    wdata_n = i2c.wdata;
    busy_n  = busy;
    done_n  = cfg_done;
    fail_n  = cfg_fail;
    fidx_n  = fail_index;
    retry_n = retry;
    ld_pwr  = 1'b0;
    ld_set  = 1'b0;
    ld_to   = 1'b0;
    adv     = 1'b0;

    unique case (state)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start) begin
          state_n = S_PWRUP;
          done_n  = 1'b0;
          fail_n  = 1'b0;
          busy_n  = 1'b1;
          idx_n   = '0;
          ld_pwr  = 1'b1;
        end
      end
      S_PWRUP: begin
        if (pwr_tc)
          state_n = (lut_size == '0) ? S_DONE : S_FETCH;
      end
      S_FETCH: begin
        addr_n  = lut_data[ADDR_MSB:ADDR_LSB];
        wdata_n = lut_data[DATA_MSB:0];
        retry_n = '0;
        state_n = S_ISSUE;
      end
      S_ISSUE: begin
        req_n   = 1'b1;
        ld_to   = 1'b1;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        // done is checked first so it wins over a same-cycle timeout
        if (i2c.done && !i2c.nack) begin
          req_n = 1'b0;
          if (i2c.addr == SWRST_ADDR) begin
            ld_set  = 1'b1;
            state_n = S_SETTLE;
          end else begin
            adv = 1'b1;
          end
        end else if (i2c.done || to_tc) begin
          req_n = 1'b0;
          if (retry < RMAX) begin
            retry_n = retry + RW'(1);
            state_n = S_ISSUE;
          end else begin
            fidx_n  = lut_index;
            state_n = S_FAIL;
          end
        end
      end
      S_SETTLE: begin
        if (set_tc)
          adv = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase

    if (adv) begin
      if (lut_index == lut_size - ONE) begin
        state_n = S_DONE;
      end else begin
        idx_n   = lut_index + ONE;
        state_n = S_FETCH;
      end
    end

    if (state_n == S_DONE) begin
      done_n = 1'b1;
      busy_n = 1'b0;
    end
    if (state_n == S_FAIL) begin
      fail_n = 1'b1;
      busy_n = 1'b0;
      req_n  = 1'b0;
    end
  end

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Bench for i2c_cfg_sequencer: scripted and random LUT passes against
// a transaction-level model of the expected write sequence and timing.
module tb_i2c_cfg_sequencer;

  localparam int IW  = 9;
  localparam int PWR = 10;
  localparam int SWC = 5;
  localparam int TO  = 20;
  localparam int MR  = 2;
  localparam logic [15:0] SWR = 16'h0103;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [IW-1:0] lut_index, lut_size, fail_index;
  logic [23:0]   lut_data;
  logic          busy, cfg_done, cfg_fail;
  logic          resp_done, resp_nack, force_done;

  i2c_cfg_sequencer_if bus();
  assign bus.done = resp_done | force_done;
  assign bus.nack = resp_nack;

  i2c_cfg_sequencer #(
    .IDX_W(IW), .PWRUP_CYCLES(PWR), .SWRST_ADDR(SWR),
    .SWRST_CYCLES(SWC), .TIMEOUT_CYCLES(TO), .MAX_RETRY(MR)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .lut_index(lut_index), .lut_data(lut_data), .lut_size(lut_size),
    .i2c(bus), .busy(busy), .cfg_done(cfg_done),
    .cfg_fail(cfg_fail), .fail_index(fail_index)
  );

  always #5 clk = ~clk;

  logic [23:0] lut_mem [16];
  int  nack_plan [16];
  int  nack_left [16];
  int  silent, ack_lat;
  bit  mute;
  int  tests, fails;

  assign lut_data = (lut_index < IW'(16)) ? lut_mem[lut_index[3:0]] : 24'h0;

  logic [15:0] o_addr[$], e_addr[$];
  logic [7:0]  o_data[$], e_data[$];
  int          o_gap[$], e_gap[$], o_dur[$], e_dur[$];
  int          low_run, hi_run;
  logic        prev_req;
  logic [15:0] cap_a;
  logic [7:0]  cap_d;

  // I2C master stand-in plus request logger
  initial begin
    resp_done = 0; resp_nack = 0;
    low_run = 0; hi_run = 0; prev_req = 0;
    forever begin
      @(negedge clk);
      resp_done = 0;
      resp_nack = 0;
      if (bus.req === 1'b1) begin
        if (!prev_req) begin
          o_addr.push_back(bus.addr);
          o_data.push_back(bus.wdata);
          o_gap.push_back(low_run);
          cap_a = bus.addr; cap_d = bus.wdata;
          hi_run = 0;
        end else begin
          tests++;
          if (bus.addr !== cap_a || bus.wdata !== cap_d) begin
            fails++;
            $display("FAIL req_stable: got %h/%h want %h/%h",
                     bus.addr, bus.wdata, cap_a, cap_d);
          end
        end
        hi_run++;
        if (!mute && int'(lut_index) != silent && hi_run == ack_lat) begin
          resp_done = 1;
          if (nack_left[lut_index[3:0]] > 0) begin
            resp_nack = 1;
            nack_left[lut_index[3:0]]--;
          end
        end
      end else begin
        if (prev_req) begin
          o_dur.push_back(hi_run);
          low_run = 0;
        end
        low_run++;
      end
      prev_req = (bus.req === 1'b1);
    end
  end

  task automatic clear_mon();
    o_addr.delete(); o_data.delete(); o_gap.delete(); o_dur.delete();
    low_run = 0;
  endtask

  task automatic set_cfg(input int lat);
    for (int i = 0; i < 16; i++) nack_plan[i] = 0;
    silent = -1;
    ack_lat = lat;
    mute = 0;
  endtask

  task automatic load_basic();
    lut_mem[0] = 24'h010301;
    lut_mem[1] = 24'h010000;
    lut_mem[2] = 24'h010001;
    lut_size = IW'(3);
  endtask

  // Expected write sequence and completion edge, counted from the start edge
  task automatic run_model(output int e_end, output bit e_fail, output int e_idx);
    int t, dur, gap;
    bit ok, prev_sw;
    e_addr.delete(); e_data.delete(); e_gap.delete(); e_dur.delete();
    t = PWR + 1;
    e_fail = 0; e_idx = 0; prev_sw = 0; e_end = 0;
    for (int i = 0; i < int'(lut_size); i++) begin
      t += 1;
      ok = 0;
      for (int a = 0; a <= MR; a++) begin
        gap = (a > 0) ? 1 : (i == 0) ? -1 : (prev_sw ? 2 + SWC : 2);
        dur = (i == silent || ack_lat > TO) ? TO : ack_lat;
        e_addr.push_back(lut_mem[i][23:8]);
        e_data.push_back(lut_mem[i][7:0]);
        e_gap.push_back(gap);
        e_dur.push_back(dur);
        t += 1 + dur;
        if (i != silent && ack_lat <= TO && a >= nack_plan[i]) begin
          ok = 1;
          break;
        end
      end
      if (!ok) begin
        e_fail = 1; e_idx = i; e_end = t;
        return;
      end
      prev_sw = (lut_mem[i][23:8] == SWR);
      if (prev_sw) t += SWC;
      e_idx = i;
    end
    e_end = t;
  endtask

  task automatic run_pass(input string name, input int xs);
    int got, e_end, e_idx, n;
    bit e_fail;
    for (int i = 0; i < 16; i++) nack_left[i] = nack_plan[i];
    run_model(e_end, e_fail, e_idx);
    @(negedge clk);
    clear_mon();
    start = 1;
    got = 0;
    for (int c = 1; c <= 4000; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        start = 0;
        tests++;
        if (busy !== 1'b1 || cfg_done !== 1'b0 || cfg_fail !== 1'b0 || lut_index !== '0) begin
          fails++;
          $display("FAIL %s start_state: got busy=%b done=%b fail=%b idx=%0d want 1 0 0 0",
                   name, busy, cfg_done, cfg_fail, lut_index);
        end
      end
      if (xs > 0 && c == xs) start = 1;
      else if (xs > 0 && c == xs + 1) start = 0;
      if (cfg_done === 1'b1 || cfg_fail === 1'b1) begin
        got = c;
        break;
      end
    end
    start = 0;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (got != e_end) begin
      fails++;
      $display("FAIL %s end_cycle: got %0d want %0d", name, got, e_end);
    end
    tests++;
    if (cfg_fail !== e_fail || cfg_done !== ~e_fail) begin
      fails++;
      $display("FAIL %s status: got done=%b fail=%b want fail=%b", name, cfg_done, cfg_fail, e_fail);
    end
    tests++;
    if (busy !== 1'b0 || bus.req !== 1'b0) begin
      fails++;
      $display("FAIL %s idle_outs: got busy=%b req=%b want 0 0", name, busy, bus.req);
    end
    tests++;
    if (lut_index !== IW'(e_idx)) begin
      fails++;
      $display("FAIL %s lut_index: got %0d want %0d", name, lut_index, e_idx);
    end
    if (e_fail) begin
      tests++;
      if (fail_index !== IW'(e_idx)) begin
        fails++;
        $display("FAIL %s fail_index: got %0d want %0d", name, fail_index, e_idx);
      end
    end
    tests++;
    if (o_addr.size() != e_addr.size() || o_dur.size() != e_addr.size()) begin
      fails++;
      $display("FAIL %s req_count: got %0d/%0d want %0d",
               name, o_addr.size(), o_dur.size(), e_addr.size());
    end
    n = e_addr.size();
    if (o_addr.size() < n) n = o_addr.size();
    if (o_dur.size() < n) n = o_dur.size();
    for (int i = 0; i < n; i++) begin
      tests++;
      if (o_addr[i] !== e_addr[i] || o_data[i] !== e_data[i] || o_dur[i] != e_dur[i] ||
          (e_gap[i] >= 0 && o_gap[i] != e_gap[i])) begin
        fails++;
        $display("FAIL %s req%0d: got %h/%h dur=%0d gap=%0d want %h/%h dur=%0d gap=%0d",
                 name, i, o_addr[i], o_data[i], o_dur[i], o_gap[i],
                 e_addr[i], e_data[i], e_dur[i], e_gap[i]);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; start = 0; force_done = 0;
    lut_size = '0;
    set_cfg(4);
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({bus.req, bus.addr, bus.wdata, lut_index, busy, cfg_done, cfg_fail, fail_index} !== '0) begin
      fails++;
      $display("FAIL reset: got req=%b addr=%h wdata=%h idx=%0d busy=%b done=%b fail=%b fidx=%0d want all 0",
               bus.req, bus.addr, bus.wdata, lut_index, busy, cfg_done, cfg_fail, fail_index);
    end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_basic();
    do_reset();
    load_basic();
    set_cfg(4);
    run_pass("basic", 0);
  endtask

  task automatic test_empty();
    do_reset();
    lut_size = '0;
    set_cfg(4);
    run_pass("empty", 0);
  endtask

  task automatic test_nack_retry();
    do_reset();
    load_basic();
    set_cfg(4);
    nack_plan[1] = 2;
    run_pass("nack_retry", 0);
  endtask

  task automatic test_timeout_fail();
    do_reset();
    load_basic();
    set_cfg(4);
    silent = 2;
    run_pass("timeout_fail", 0);
  endtask

  task automatic test_nack_exhaust();
    do_reset();
    lut_mem[0] = 24'h3a0155;
    lut_mem[1] = 24'h3a02aa;
    lut_size = IW'(2);
    set_cfg(3);
    nack_plan[0] = MR + 1;
    run_pass("nack_exhaust", 0);
  endtask

  task automatic test_done_at_timeout();
    do_reset();
    lut_mem[0] = 24'h301812;
    lut_mem[1] = 24'h3019c4;
    lut_size = IW'(2);
    set_cfg(TO);
    run_pass("done_at_timeout", 0);
  endtask

  task automatic test_start_while_busy();
    do_reset();
    load_basic();
    set_cfg(4);
    run_pass("start_in_pwrup", 5);
    run_pass("start_in_wait", 16);
  endtask

  task automatic test_back_to_back();
    do_reset();
    load_basic();
    set_cfg(2);
    run_pass("b2b_first", 0);
    set_cfg(5);
    nack_plan[0] = 1;
    run_pass("b2b_second", 0);
    silent = 1;
    run_pass("b2b_after_fail_a", 0);
    silent = -1;
    run_pass("b2b_after_fail_b", 0);
  endtask

  task automatic test_reset_mid_wait();
    int w;
    do_reset();
    load_basic();
    set_cfg(4);
    mute = 1;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    w = 0;
    while (bus.req !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    tests++;
    if (bus.req !== 1'b1) begin
      fails++;
      $display("FAIL mid_wait_req: got %b want 1", bus.req);
    end
    repeat (3) @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    tests++;
    if ({bus.req, bus.addr, bus.wdata, lut_index, busy, cfg_done, cfg_fail, fail_index} !== '0) begin
      fails++;
      $display("FAIL mid_wait_reset: got req=%b addr=%h idx=%0d busy=%b want 0",
               bus.req, bus.addr, lut_index, busy);
    end
    @(negedge clk);
    rst = 0;
    force_done = 1;
    @(negedge clk);
    force_done = 0;
    repeat (5) @(negedge clk);
    tests++;
    if ({bus.req, busy, cfg_done, cfg_fail, lut_index, bus.addr} !== '0) begin
      fails++;
      $display("FAIL late_done: got req=%b busy=%b done=%b fail=%b idx=%0d want 0",
               bus.req, busy, cfg_done, cfg_fail, lut_index);
    end
    mute = 0;
  endtask

  task automatic test_random();
    string nm;
    for (int it = 0; it < 8; it++) begin
      do_reset();
      set_cfg(int'($urandom_range(1, 8)));
      lut_size = IW'($urandom_range(1, 6));
      for (int i = 0; i < 16; i++) begin
        lut_mem[i][23:8] = ($urandom_range(0, 3) == 0) ? SWR : 16'($urandom);
        lut_mem[i][7:0]  = 8'($urandom);
        nack_plan[i] = ($urandom_range(0, 7) == 0) ? MR + 1 : int'($urandom_range(0, MR));
      end
      nm = $sformatf("random%0d", it);
      run_pass(nm, 0);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_basic();
    test_empty();
    test_nack_retry();
    test_timeout_fail();
    test_nack_exhaust();
    test_done_at_timeout();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2c_cfg_sequencer.md
Name: i2c_cfg_sequencer

Overview:
- Walks a sensor register-configuration LUT (24-bit entries: {16-bit reg addr, 8-bit data}; entry count from LUT_SIZE) and issues each entry as one I2C register write through the existing I2C master.
- Sits between the sensor config LUT (e.g. the SC2210 4-lane table) and the I2C byte engine.
- Adds a power-up wait, a settle delay after the soft-reset register write, per-write timeout and retries, and reports done/fail status to the system.

Parameters:
- IDX_W, 9, width of the LUT index and size.
- PWRUP_CYCLES, 20000, clk cycles to wait after start before the first write.
- SWRST_ADDR, 16'h0103, register address that triggers the post-write settle delay.
- SWRST_CYCLES, 10000, settle cycles after a successful write to SWRST_ADDR.
- TIMEOUT_CYCLES, 65535, max cycles waiting for i2c_done before the write counts as failed.
- MAX_RETRY, 3, extra attempts per entry after the first failure.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a configuration pass.
- lut_index  out  IDX_W  LUT entry address.
- lut_data  in  24  entry at lut_index; combinational, valid the cycle after lut_index changes.
- lut_size  in  IDX_W  number of entries; static during a pass.
- i2c_req  out  1  write request, level.
- i2c_addr  out  16  register address; stable while i2c_req=1.
- i2c_wdata  out  8  register data; stable while i2c_req=1.
- i2c_done  in  1  one-cycle pulse from the master: transaction finished.
- i2c_nack  in  1  qualified by i2c_done; 1 = slave NACK.
- busy  out  1  pass in progress.
- cfg_done  out  1  sticky; all entries written.
- cfg_fail  out  1  sticky; retries exhausted.
- fail_index  out  IDX_W  entry that failed; valid while cfg_fail=1.

Behaviour:
- Reset: state IDLE; lut_index=0, i2c_req=0, i2c_addr=0, i2c_wdata=0, busy=0, cfg_done=0, cfg_fail=0, fail_index=0, all counters 0. Reset mid-transaction drops i2c_req on the next edge; any later i2c_done is ignored.
- States: IDLE, PWRUP, FETCH, ISSUE, WAIT, SETTLE, DONE, FAIL.
- IDLE: on start, clear cfg_done/cfg_fail, set busy=1, lut_index=0, go PWRUP. start is ignored in every state other than IDLE, DONE and FAIL. DONE and FAIL behave as IDLE for start.
- PWRUP: count PWRUP_CYCLES cycles. If lut_size=0, go DONE; else go FETCH.
- FETCH: one cycle; lut_index is already stable. Latch i2c_addr=lut_data[23:8] and i2c_wdata=lut_data[7:0]. Clear the retry count and go ISSUE.
- ISSUE: assert i2c_req=1, clear the timeout counter, go WAIT.
- WAIT:
  - i2c_req is held until i2c_done and deasserts on the cycle after i2c_done.
  - Success (i2c_done & !i2c_nack): if i2c_addr==SWRST_ADDR go SETTLE, else advance.
  - Failure is i2c_done & i2c_nack, or the timeout counter reaching TIMEOUT_CYCLES-1.
  - On failure with retry count < MAX_RETRY: increment it, drop i2c_req for one cycle, go ISSUE with the same addr/data.
  - On failure with retries exhausted: fail_index=lut_index, go FAIL.
  - i2c_done on the same cycle as timeout expiry: i2c_done wins.
- SETTLE: count SWRST_CYCLES cycles, then advance.
- Advance: if lut_index==lut_size-1, go DONE; else lut_index+1 and go FETCH. The index never wraps.
- DONE: cfg_done=1, busy=0.
- FAIL: cfg_fail=1, busy=0, i2c_req=0.
- Latency per entry with an ideal master (i2c_done N cycles after ISSUE): 2+N cycles from FETCH entry to next FETCH entry.
- All counters are saturating and sized with $clog2 of their parameter.

Decomposition:
- Shared package cfg_seq_pkg: state enum, LUT entry field positions ADDR_MSB=23/ADDR_LSB=8/DATA_MSB=7, and the default SWRST_ADDR.
- One sub-module is natural: cfg_delay_cnt, a loadable down-counter with a terminal-count pulse, reused for PWRUP, SETTLE and timeout.

Test Plan (PWRUP_CYCLES=10, SWRST_CYCLES=5, TIMEOUT_CYCLES=20, MAX_RETRY=2 unless stated):
- 3-entry LUT {0103/01, 0100/00, 0100/01}, master acks in 4 cycles:
  - three writes in order;
  - 5-cycle gap after 0103;
  - cfg_done=1, busy=0;
  - lut_index ends at 2.
- lut_size=0, start → cfg_done=1 eleven cycles after start, and i2c_req is never asserted.
- Entry 1 NACKed twice then acked → three requests with identical addr/data, each separated by i2c_req low for 1 cycle; the pass completes with cfg_done=1.
- Entry 2 never answered (no i2c_done) → 3 timeouts of 20 cycles each, then cfg_fail=1, fail_index=2, i2c_req=0.
- Mid-WAIT reset, then a late i2c_done pulse → all outputs at reset values; the late i2c_done is ignored and the state stays IDLE.
- start pulsed while busy → ignored. start after DONE → cfg_done clears and a new pass starts from index 0.
